// File: rtl/vga_pkg.sv
// Shared raster timing types and default 640x480@60 timing.
package vga_pkg;

    localparam int VGA_H_DISPLAY = 640;
    localparam int VGA_H_FRONT   = 16;
    localparam int VGA_H_SYNC    = 96;
    localparam int VGA_H_BACK    = 48;
    localparam int VGA_V_DISPLAY = 480;
    localparam int VGA_V_FRONT   = 10;
    localparam int VGA_V_SYNC    = 2;
    localparam int VGA_V_BACK    = 33;

    // Widest coordinate the pipeline bundle can carry.
    localparam int VGA_XY_W = 16;

    typedef struct packed {
        logic                hs;
        logic                vs;
        logic                vid;
        logic [VGA_XY_W-1:0] x;
        logic [VGA_XY_W-1:0] y;
        logic                ls;
        logic                fs;
    } vga_timing_t;

    function automatic int vga_total(
        input int disp,
        input int front,
        input int sync,
        input int back
    );
        return disp + front + sync + back;
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle between the generator and its consumers.
interface vga_timing_gen_if #(
    parameter int COUNT_W = 10,
    parameter int FRAME_W = 8
);
    logic               pix_ce;
    logic               hsync;
    logic               vsync;
    logic               video_on;
    logic [COUNT_W-1:0] pixel_x;
    logic [COUNT_W-1:0] pixel_y;
    logic               line_start;
    logic               frame_start;
    logic [FRAME_W-1:0] frame_count;

    modport master (
        input  pix_ce,
        output hsync, vsync, video_on,
        output pixel_x, pixel_y,
        output line_start, frame_start,
        output frame_count
    );

    modport slave (
        output pix_ce,
        input  hsync, vsync, video_on,
        input  pixel_x, pixel_y,
        input  line_start, frame_start,
        input  frame_count
    );
endinterface

// File: rtl/vga_delay_line.sv
// Clock-enabled shift register; also exposes the value feeding the last stage.
module vga_delay_line #(
    parameter int               DEPTH   = 1,
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [WIDTH-1:0] tail_in
);

    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [WIDTH-1:0] stage_d [DEPTH];

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i];
        end
        if (ce) begin
            stage_d[0] = din;
            for (int i = 1; i < DEPTH; i++) begin
                stage_d[i] = stage_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= RST_VAL;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    assign dout = stage_q[DEPTH-1];

    generate
        if (DEPTH == 1) begin : g_one
            assign tail_in = din;
        end else begin : g_many
            assign tail_in = stage_q[DEPTH-2];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator with pix_ce-gated counters,
// a registered output pipeline, line/frame strobes and a frame counter.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_DISPLAY   = VGA_H_DISPLAY,
    parameter int H_FRONT     = VGA_H_FRONT,
    parameter int H_SYNC      = VGA_H_SYNC,
    parameter int H_BACK      = VGA_H_BACK,
    parameter int V_DISPLAY   = VGA_V_DISPLAY,
    parameter int V_FRONT     = VGA_V_FRONT,
    parameter int V_SYNC      = VGA_V_SYNC,
    parameter int V_BACK      = VGA_V_BACK,
    parameter bit HS_POL      = 1'b0,
    parameter bit VS_POL      = 1'b0,
    parameter int PIPE_STAGES = 1,
    parameter int COUNT_W     = 10,
    parameter int FRAME_W     = 8
) (
    input logic              clk_25mhz,
    input logic              reset,
    vga_timing_gen_if.master vif
);

    localparam int H_TOTAL =
        vga_total(H_DISPLAY, H_FRONT, H_SYNC, H_BACK);
    localparam int V_TOTAL =
        vga_total(V_DISPLAY, V_FRONT, V_SYNC, V_BACK);

    generate
        if (H_DISPLAY <= 0 || H_FRONT <= 0 || H_SYNC <= 0 ||
            H_BACK <= 0 || V_DISPLAY <= 0 || V_FRONT <= 0 ||
            V_SYNC <= 0 || V_BACK <= 0) begin : g_bad_timing
            $error("vga_timing_gen: timing parameter must be > 0");
        end
        if (PIPE_STAGES < 1 || PIPE_STAGES > 8) begin : g_bad_pipe
            $error("vga_timing_gen: PIPE_STAGES must be 1..8");
        end
        if (COUNT_W < 1 || COUNT_W > VGA_XY_W ||
            H_TOTAL > (1 << COUNT_W) ||
            V_TOTAL > (1 << COUNT_W)) begin : g_bad_width
            $error("vga_timing_gen: COUNT_W too small for totals");
        end
    endgenerate

    localparam logic [COUNT_W-1:0] H_LAST =
        COUNT_W'(H_TOTAL - 1);
    localparam logic [COUNT_W-1:0] V_LAST =
        COUNT_W'(V_TOTAL - 1);
    localparam logic [COUNT_W-1:0] H_DISP = COUNT_W'(H_DISPLAY);
    localparam logic [COUNT_W-1:0] V_DISP = COUNT_W'(V_DISPLAY);
    localparam logic [COUNT_W-1:0] H_SS =
        COUNT_W'(H_DISPLAY + H_FRONT);
    localparam logic [COUNT_W-1:0] H_SE =
        COUNT_W'(H_DISPLAY + H_FRONT + H_SYNC);
    localparam logic [COUNT_W-1:0] V_SS =
        COUNT_W'(V_DISPLAY + V_FRONT);
    localparam logic [COUNT_W-1:0] V_SE =
        COUNT_W'(V_DISPLAY + V_FRONT + V_SYNC);

    localparam vga_timing_t IDLE = '{
        hs: ~HS_POL, vs: ~VS_POL, default: '0
    };

    logic [COUNT_W-1:0] h_cnt_q, h_cnt_d;
    logic [COUNT_W-1:0] v_cnt_q, v_cnt_d;
    logic               line_start_q, line_start_d;
    logic               frame_start_q, frame_start_d;
    logic [FRAME_W-1:0] frame_count_q, frame_count_d;

    vga_timing_t raw;
    vga_timing_t pipe_out;
    vga_timing_t pipe_tail;

    always_comb begin
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (vif.pix_ce) begin
            if (h_cnt_q == H_LAST) begin
                h_cnt_d = '0;
                v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
            end else begin
                h_cnt_d = h_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        raw     = IDLE;
        raw.hs  = (h_cnt_q >= H_SS && h_cnt_q < H_SE) ?
                  HS_POL : ~HS_POL;
        raw.vs  = (v_cnt_q >= V_SS && v_cnt_q < V_SE) ?
                  VS_POL : ~VS_POL;
        raw.vid = (h_cnt_q < H_DISP) && (v_cnt_q < V_DISP);
        raw.x   = (h_cnt_q < H_DISP) ? VGA_XY_W'(h_cnt_q) : '0;
        raw.y   = (v_cnt_q < V_DISP) ? VGA_XY_W'(v_cnt_q) : '0;
        raw.ls  = (h_cnt_q == '0) && (v_cnt_q < V_DISP);
        raw.fs  = (h_cnt_q == '0) && (v_cnt_q == '0);
    end

    vga_delay_line #(
        .DEPTH  (PIPE_STAGES),
        .WIDTH  ($bits(vga_timing_t)),
        .RST_VAL(IDLE)
    ) u_pipe (
        .clk    (clk_25mhz),
        .rst    (reset),
        .ce     (vif.pix_ce),
        .din    (raw),
        .dout   (pipe_out),
        .tail_in(pipe_tail)
    );

    // Strobes fire only on the cycle the flag lands in the last stage.
    always_comb begin
        line_start_d  = vif.pix_ce & pipe_tail.ls;
        frame_start_d = vif.pix_ce & pipe_tail.fs;
        frame_count_d = frame_count_q + FRAME_W'(frame_start_d);
    end

    always_ff @(posedge clk_25mhz or posedge reset) begin
        if (reset) begin
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            frame_count_q <= '0;
        end else begin
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign vif.hsync       = pipe_out.hs;
    assign vif.vsync       = pipe_out.vs;
    assign vif.video_on    = pipe_out.vid;
    assign vif.pixel_x     = pipe_out.x[COUNT_W-1:0];
    assign vif.pixel_y     = pipe_out.y[COUNT_W-1:0];
    assign vif.line_start  = line_start_q;
    assign vif.frame_start = frame_start_q;
    assign vif.frame_count = frame_count_q;

endmodule
